alu_muldiv: RTL and testbench

- Next-generation execute-stage arithmetic unit.
- Combinational ALU generalised to WIDTH bits, with the same 12-bit one-hot control encoding.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/done handshake.
- The pipeline stalls on md_busy while a multiply or divide is in flight.

---
 rtl/alu_muldiv.sv | 124 ++++++++++++
 tb/tb_alu_muldiv.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: combinational one-hot ALU plus an iterative radix-2 multiply/divide unit
// with HI/LO registers and a start/done handshake.
module alu_muldiv #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      alu_control,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       md_op,
    input  logic             md_valid,
    input  logic             md_cancel,
    input  logic [1:0]       hilo_we,
    output logic             md_ready,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t state, next;
    logic [WIDTH:0] diff;
    logic slt, sltu;
    logic [SHW-1:0] sh;
    logic [WIDTH-1:0] sra_v;

    assign diff  = {1'b0, alu_src1} - {1'b0, alu_src2};
    assign slt   = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) ? alu_src1[WIDTH-1] : diff[WIDTH-1];
    assign sltu  = diff[WIDTH];
    assign sh    = alu_src1[SHW-1:0];
    assign sra_v = $signed(alu_src2) >>> sh;

    always_comb
        alu_result = ({WIDTH{alu_control[11]}} & (alu_src1 + alu_src2))
                   | ({WIDTH{alu_control[10]}} & diff[WIDTH-1:0])
                   | ({WIDTH{alu_control[9]}}  & {{(WIDTH-1){1'b0}}, slt})
                   | ({WIDTH{alu_control[8]}}  & {{(WIDTH-1){1'b0}}, sltu})
                   | ({WIDTH{alu_control[7]}}  & (alu_src1 & alu_src2))
                   | ({WIDTH{alu_control[6]}}  & ~(alu_src1 | alu_src2))
                   | ({WIDTH{alu_control[5]}}  & (alu_src1 | alu_src2))
                   | ({WIDTH{alu_control[4]}}  & (alu_src1 ^ alu_src2))
                   | ({WIDTH{alu_control[3]}}  & (alu_src2 << sh))
                   | ({WIDTH{alu_control[2]}}  & (alu_src2 >> sh))
                   | ({WIDTH{alu_control[1]}}  & sra_v)
                   | ({WIDTH{alu_control[0]}}  & {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}});

    logic [2*WIDTH-1:0] acc, step_next, p_fix, result;
    logic [WIDTH-1:0] opb, a_raw, mag_a, mag_b, q_fix, r_fix;
    logic neg_a, neg_b, is_div, accept, in_signed, in_div;
    logic [SHW-1:0] cnt;
    logic [WIDTH:0] mul_sum, div_tmp, div_dif;

    assign accept    = (state == IDLE) && md_valid && (md_op != 4'b0);
    assign in_signed = md_op[3] || (!md_op[2] && md_op[1]);
    assign in_div    = !md_op[3] && !md_op[2];
    assign mag_a     = (in_signed && alu_src1[WIDTH-1]) ? -alu_src1 : alu_src1;
    assign mag_b     = (in_signed && alu_src2[WIDTH-1]) ? -alu_src2 : alu_src2;

    // acc holds {partial product} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign div_tmp = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_dif = div_tmp - {1'b0, opb};
    assign step_next = (state == MUL) ? {mul_sum, acc[WIDTH-1:1]}
                     : div_dif[WIDTH] ? {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                     : {div_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign p_fix  = (neg_a ^ neg_b) ? -acc : acc;
    assign q_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign result = !is_div ? p_fix
                  : (opb == '0) ? {a_raw, {WIDTH{1'b1}}}
                  : {r_fix, q_fix};

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = accept ? (in_div ? DIV : MUL) : IDLE;
            MUL, DIV: next = md_cancel ? IDLE : (cnt == SHW'(WIDTH - 1)) ? FIX : state;
            FIX:      next = md_cancel ? IDLE : DONE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    assign md_ready = (state == IDLE);
    assign md_busy  = !md_ready;
    assign md_done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            opb    <= '0;
            a_raw  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            is_div <= 1'b0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && hilo_we[1]) hi <= alu_src1;
            if (state == IDLE && hilo_we[0]) lo <= alu_src1;
            if (accept) begin
                acc    <= {{WIDTH{1'b0}}, mag_a};
                opb    <= mag_b;
                a_raw  <= alu_src1;
                neg_a  <= in_signed && alu_src1[WIDTH-1];
                neg_b  <= in_signed && alu_src2[WIDTH-1];
                is_div <= in_div;
                cnt    <= '0;
            end else if (state == MUL || state == DIV) begin
                acc <= step_next;
                cnt <= cnt + SHW'(1);
            end
            if (state == FIX && !md_cancel) {hi, lo} <= result;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv at WIDTH=32 and WIDTH=16.
module tb_alu_muldiv;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, cancel, ready, busy, done;
    logic [11:0] ctl;
    logic [31:0] src1, src2, res, hi, lo;
    logic [3:0]  op;
    logic [1:0]  we;

    logic        rst16, valid16, cancel16, ready16, busy16, done16;
    logic [11:0] ctl16;
    logic [15:0] src1_16, src2_16, res16, hi16, lo16;
    logic [3:0]  op16;
    logic [1:0]  we16;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .alu_control(ctl), .alu_src1(src1), .alu_src2(src2),
        .alu_result(res), .md_op(op), .md_valid(valid), .md_cancel(cancel), .hilo_we(we),
        .md_ready(ready), .md_busy(busy), .md_done(done), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .alu_control(ctl16), .alu_src1(src1_16), .alu_src2(src2_16),
        .alu_result(res16), .md_op(op16), .md_valid(valid16), .md_cancel(cancel16), .hilo_we(we16),
        .md_ready(ready16), .md_busy(busy16), .md_done(done16), .hi(hi16), .lo(lo16)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        logic signed [31:0] sa, sb, q, r;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        sa = a;
        sb = b;
        if (o[3]) return ea * eb;
        if (o[2]) return {32'b0, a} * {32'b0, b};
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (o[1]) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    always @(negedge clk)
        if (done) begin
            check("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                check("md_hi", 64'(hi), 64'(exp_v[63:32]));
                check("md_lo", 64'(lo), 64'(exp_v[31:0]));
            end
        end

    task automatic md_run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input logic [1:0] w, input bit extra);
        int e;
        @(negedge clk);
        op = o; src1 = a; src2 = b; we = w; valid = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        valid = 1'b0; we = 2'b00; src1 = $urandom; src2 = $urandom;
        if (w[1]) check("accept_we_hi", 64'(hi), 64'(a));
        if (w[0]) check("accept_we_lo", 64'(lo), 64'(a));
        check("accept_busy", 64'(busy), 64'd1);
        e = 0;
        while (!done && e < 60) begin
            @(negedge clk);
            e++;
            if (extra && e == 4) begin
                valid = 1'b1;
                op = 4'b0001;
            end
            if (e == 5) valid = 1'b0;
            if (e == 20) check("mid_busy", 64'(busy), 64'd1);
        end
        check("md_latency", 64'(e), 64'd33);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("ready_after", 64'(ready), 64'd1);
    endtask

    typedef struct packed {
        logic [11:0] c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } alu_vec_t;
    alu_vec_t alu_tab[16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [3:0] ro;
        logic [31:0] ra, rb;
        alu_tab = '{
            '{12'h800, 32'h7FFFFFFF, 32'h00000001, 32'h80000000},
            '{12'h400, 32'h00000005, 32'h00000007, 32'hFFFFFFFE},
            '{12'h200, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
            '{12'h100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
            '{12'h200, 32'h00000001, 32'hFFFFFFFF, 32'h00000000},
            '{12'h100, 32'h00000001, 32'hFFFFFFFF, 32'h00000001},
            '{12'h200, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001},
            '{12'h080, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
            '{12'h040, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F},
            '{12'h020, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0},
            '{12'h010, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0},
            '{12'h008, 32'h00000024, 32'h00000001, 32'h00000010},
            '{12'h004, 32'h00000004, 32'h80000000, 32'h08000000},
            '{12'h002, 32'h00000004, 32'h80000000, 32'hF8000000},
            '{12'h001, 32'h00000000, 32'h00001234, 32'h12340000},
            '{12'h000, 32'h00000005, 32'h00000005, 32'h00000000}
        };
        rst = 1'b1; valid = 1'b0; cancel = 1'b0; we = 2'b00; op = 4'b0; ctl = 12'h0; src1 = '0; src2 = '0;
        rst16 = 1'b1; valid16 = 1'b0; cancel16 = 1'b0; we16 = 2'b00; op16 = 4'b0; ctl16 = 12'h0;
        src1_16 = '0; src2_16 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst16 = 1'b0;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst16_busy", 64'(busy16), 64'd0);

        foreach (alu_tab[i]) begin
            ctl = alu_tab[i].c; src1 = alu_tab[i].a; src2 = alu_tab[i].b;
            #1;
            check($sformatf("alu%0d", i), 64'(res), 64'(alu_tab[i].y));
        end
        ctl = 12'h0;

        md_run(4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 2'b00, 1'b1);
        md_run(4'b1000, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 2'b00, 1'b0);
        md_run(4'b0010, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 2'b00, 1'b0);
        md_run(4'b0010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 2'b00, 1'b0);
        md_run(4'b0010, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, 2'b00, 1'b0);
        md_run(4'b1111, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 2'b11, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ro = 4'b0001 << $urandom_range(0, 3);
            ra = $urandom;
            rb = (i == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            md_run(ro, ra, rb, model(ro, ra, rb), 2'b00, 1'b0);
        end
        md_run(4'b0001, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 2'b00, 1'b0);

        @(negedge clk);
        op = 4'b0010; src1 = 32'd100; src2 = 32'd7; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        we = 2'b10; src1 = 32'h0000DEAD;
        @(negedge clk);
        we = 2'b00;
        check("we_busy_hi", 64'(hi), 64'd5);
        repeat (6) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_ready", 64'(ready), 64'd1);
        check("cancel_hi", 64'(hi), 64'd5);
        check("cancel_lo", 64'(lo), 64'hFFFFFFFF);
        repeat (40) @(negedge clk);
        check("cancel_hi_later", 64'(hi), 64'd5);
        check("cancel_lo_later", 64'(lo), 64'hFFFFFFFF);

        src1 = 32'hA5; we = 2'b01;
        @(negedge clk);
        we = 2'b00;
        check("we_lo", 64'(lo), 64'hA5);
        check("we_lo_hi_kept", 64'(hi), 64'd5);
        src1 = 32'h1234; we = 2'b10;
        @(negedge clk);
        we = 2'b00;
        check("we_hi", 64'(hi), 64'h1234);
        check("we_hi_lo_kept", 64'(lo), 64'hA5);

        op = 4'b1000; src1 = 32'd12345; src2 = 32'd678; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_ready", 64'(ready), 64'd1);
        check("rst_mid_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        check("rst_mid_queue", 64'(exp_q.size()), 64'd0);

        ctl16 = 12'h001; src1_16 = 16'h0; src2_16 = 16'h00AB;
        #1;
        check("lui16", 64'(res16), 64'hAB00);
        ctl16 = 12'h008; src1_16 = 16'h0013; src2_16 = 16'h0001;
        #1;
        check("sll16", 64'(res16), 64'h0008);
        ctl16 = 12'h0;
        @(negedge clk);
        op16 = 4'b0100; src1_16 = 16'hFFFF; src2_16 = 16'hFFFF; valid16 = 1'b1;
        @(negedge clk);
        valid16 = 1'b0; src1_16 = 16'h0; src2_16 = 16'h0;
        e = 0;
        while (!done16 && e < 40) begin
            @(negedge clk);
            e++;
        end
        check("md16_latency", 64'(e), 64'd17);
        check("md16_hi", 64'(hi16), 64'hFFFE);
        check("md16_lo", 64'(lo16), 64'h0001);
        @(negedge clk);
        check("md16_ready", 64'(ready16), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
